// File: rtl/pfb_deadlock_pkg.sv
// Shared types and constants for the PFB deadlock reporter.
// Optional timestamp capture is enabled by defining PFB_DEADLOCK_TIMESTAMP_EN.
package pfb_deadlock_pkg;

    // Detection FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        TRIPPED = 2'd2
    } state_e;

    // Width of the free-running cycle counter and trip timestamp
    localparam int TS_W = 64;

    // Index width for n monitors; a single monitor still gets a 1-bit index
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pfb_deadlock_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest asserted request.
// Returns 0 when no request is set; callers only sample it while a bit is set.
module pfb_deadlock_prio_enc
    import pfb_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int IDX_W   = calc_idx_w(NUM_MON)
) (
    input  logic [NUM_MON-1:0] req,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pfb_deadlock_reporter.sv
// Aggregates per-process block flags from the deadlock monitors and declares a
// deadlock once any flag has persisted for THRESH consecutive cycles. The
// tripping monitor, the flag snapshot and a stall statistic are held sticky
// until clear or reset.
// Define PFB_DEADLOCK_TIMESTAMP_EN to capture a 64-bit cycle count at trip;
// otherwise trip_time is tied to zero.
module pfb_deadlock_reporter
    import pfb_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = calc_idx_w(NUM_MON)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               deadlock,
    output logic               deadlock_pulse,
    output logic [IDX_W-1:0]   deadlock_idx,
    output logic [NUM_MON-1:0] deadlock_mask,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [TS_W-1:0]    trip_time
);

    // Persistence counter is sized so THRESH-1 always fits
    localparam int             P_W    = $clog2(THRESH) + 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(THRESH - 1);

    state_e               state_q, state_d;
    logic [P_W-1:0]       p_q, p_d;
    logic                 deadlock_q, deadlock_d;
    logic                 pulse_q, pulse_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_MON-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]     stall_q, stall_d;

    logic                 any_blk;
    logic                 trip;
    logic [IDX_W-1:0]     enc_idx;

    assign any_blk = |mon_block;
    // Final persistence cycle reached with the flags still up
    assign trip    = (state_q == COUNT) && any_blk && (p_q == P_LAST);

    pfb_deadlock_prio_enc #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req (mon_block),
        .idx (enc_idx)
    );

    // Persistence FSM: any drop of the flags restarts the count from scratch
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        if (clear) begin
            state_d = IDLE;
            p_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_blk) begin
                        state_d = COUNT;
                        p_d     = P_W'(1);
                    end
                end
                COUNT: begin
                    if (!any_blk) begin
                        state_d = IDLE;
                        p_d     = '0;
                    end else if (p_q == P_LAST) begin
                        state_d = TRIPPED;
                        p_d     = '0;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end
                TRIPPED: begin
                    state_d = TRIPPED;
                end
                default: begin
                    state_d = IDLE;
                    p_d     = '0;
                end
            endcase
        end
    end

    // Sticky status and saturating stall statistic; clear overrides a trip
    always_comb begin
        deadlock_d = deadlock_q;
        pulse_d    = 1'b0;
        idx_d      = idx_q;
        mask_d     = mask_q;
        stall_d    = stall_q;
        if (clear) begin
            deadlock_d = 1'b0;
            idx_d      = '0;
            mask_d     = '0;
            stall_d    = '0;
        end else begin
            if (any_blk && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (trip) begin
                deadlock_d = 1'b1;
                pulse_d    = 1'b1;
                idx_d      = enc_idx;
                mask_d     = mon_block;
            end
        end
    end

    // State and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            p_q        <= '0;
            deadlock_q <= 1'b0;
            pulse_q    <= 1'b0;
            idx_q      <= '0;
            mask_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            deadlock_q <= deadlock_d;
            pulse_q    <= pulse_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            stall_q    <= stall_d;
        end
    end

`ifdef PFB_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_q, cyc_d;
    logic [TS_W-1:0] trip_time_q, trip_time_d;

    // Free-running cycle counter ignores clear; timestamp follows trip/clear
    always_comb begin
        cyc_d       = cyc_q + TS_W'(1);
        trip_time_d = trip_time_q;
        if (clear) begin
            trip_time_d = '0;
        end else if (trip) begin
            trip_time_d = cyc_q;
        end
    end

    // Timestamp registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q       <= '0;
            trip_time_q <= '0;
        end else begin
            cyc_q       <= cyc_d;
            trip_time_q <= trip_time_d;
        end
    end

    assign trip_time = trip_time_q;
`else
    assign trip_time = '0;
`endif

    assign deadlock       = deadlock_q;
    assign deadlock_pulse = pulse_q;
    assign deadlock_idx   = idx_q;
    assign deadlock_mask  = mask_q;
    assign stall_cycles   = stall_q;

endmodule

// File: doc/pfb_deadlock_reporter.md
# pfb_deadlock_reporter

Aggregates the per-process `block` flags produced by the decimator's deadlock monitors, one per HLS dataflow process such as the write-outputs stage. Declares a deadlock only when any flag persists for a configurable number of consecutive cycles. On declaration it latches which monitor tripped, the full flag snapshot and a stall statistic into sticky status registers for software and ILA readout. Sits directly downstream of the monitor instances, inside the decimator's debug wrapper.

## Interface
- NUM_MON, 4, number of monitor `block` inputs (1..32)
- THRESH, 1024, consecutive blocked cycles required to declare deadlock (>= 2)
- CNT_W, 32, width of the stall-cycle counter
- IDX_W, $clog2(NUM_MON) (min 1), width of the index output (derived)
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- mon_block  in  NUM_MON  per-monitor block flags, bit i from monitor i
- clear  in  1  one-cycle pulse; clears sticky status and counters
- deadlock  out  1  sticky deadlock flag
- deadlock_pulse  out  1  single-cycle strobe on the declaring cycle
- deadlock_idx  out  IDX_W  lowest-numbered monitor set at trip
- deadlock_mask  out  NUM_MON  mon_block snapshot at trip
- stall_cycles  out  CNT_W  saturating count of cycles with any mon_block bit set
- trip_time  out  64  free-running cycle count at trip; 0 when the feature is disabled

## Operation
- any_blk = OR of mon_block.
- FSM states:
  - IDLE: persist count p = 0. If any_blk, go to COUNT with p = 1.
  - COUNT: if !any_blk, return to IDLE with p = 0. Else p = p + 1. If p == THRESH - 1 while any_blk, go to TRIPPED.
  - TRIPPED: held until clear or reset. mon_block is ignored for detection.
- On the COUNT→TRIPPED transition, register in the same edge:
  - deadlock = 1, deadlock_pulse = 1
  - deadlock_idx = priority encode (lowest index) of the current mon_block
  - deadlock_mask = current mon_block
  - trip_time = cycle counter
- deadlock_pulse is high exactly one cycle per trip.
- p is $clog2(THRESH)+1 bits and never exceeds THRESH - 1.
- stall_cycles increments on every cycle with any_blk, in every state, and saturates at all-ones (no wrap).
- A one-cycle drop of any_blk in COUNT fully restarts persistence. There is no hysteresis.
- clear: state → IDLE; p, stall_cycles, deadlock, deadlock_idx, deadlock_mask and trip_time → 0. If clear coincides with a trip condition or any_blk, clear wins: no pulse, and stall_cycles = 0 (that cycle is not counted).
- Reset state of every output is 0, with state IDLE. Reset mid-COUNT discards the partial persistence.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Trip latency: if any_blk is high on cycles 0..THRESH-1, deadlock and deadlock_pulse are high from the clock edge ending cycle THRESH-1. Both are visible in cycle THRESH.
- stall_cycles reflects any_blk with one cycle of latency.
- clear takes effect on the next edge. Detection may restart in the cycle after clear.

## Configuration
- PFB_DEADLOCK_TIMESTAMP_EN defined:
  - a 64-bit free-running cycle counter runs from reset, wraps, and is unaffected by clear
  - trip_time captures it on trip and clears on clear
- Not defined: no counter is instantiated, trip_time is tied to 0, and all other behaviour is identical.

## Structure
- Package pfb_deadlock_pkg holds:
  - the FSM state enum (IDLE, COUNT, TRIPPED)
  - the TS_W = 64 constant
  - the function computing IDX_W
- One sub-module, pfb_deadlock_prio_enc: parameterised lowest-set-bit encoder (NUM_MON → IDX_W), purely combinational, instantiated once.

## Test plan
- THRESH=8, mon_block=4'b0100 held 8 cycles → deadlock and pulse rise in cycle 8; idx=2, mask=4'b0100; pulse low in cycle 9.
- THRESH=8, mon_block=4'b0001 for 7 cycles, 0 for 1 cycle, then 4'b0001 for 7 cycles → no trip; stall_cycles=14.
- mon_block=4'b1010 held to trip → idx=1, mask=4'b1010; later mon_block changes do not alter idx or mask.
- After trip, pulse clear → all outputs 0 next cycle; re-block 8 cycles → second trip with a second single pulse.
- clear asserted in the exact trip cycle → deadlock stays 0, no pulse, stall_cycles=0.
- CNT_W=4, any_blk held 20 cycles → stall_cycles saturates at 15. With PFB_DEADLOCK_TIMESTAMP_EN and reset released at cycle 0, a trip at cycle 8 gives trip_time=7.
